decoder3to8_buf: RTL and testbench
==================================

# decoder3to8_buf

Buffered, handshaked 3-to-8 one-hot decoder: accepts 3-bit priority codes produced by the 8-to-3 encoder path, queues them in a small FIFO, and presents each as a registered one-hot 8-bit vector. It sits on the receive side of the encoded-index link and converts codes back into one-hot select/grant lines for downstream logic that may stall.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of the `count` output (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of FIFO and output stage
- in_valid  input  1  in_code is valid
- in_ready  output  1  block can accept in_code this cycle
- in_code  input  3  encoded index, 0..7
- in_par  input  1  even-parity bit over in_code; present only with DEC_PARITY_EN
- out_valid  output  1  out_onehot holds a decoded entry
- out_ready  input  1  consumer accepts out_onehot this cycle
- out_onehot  output  8  one-hot decode, bit[in_code] set
- count  output  CW  entries held, FIFO plus output register, 0..DEPTH+1
- par_err  output  1  one-cycle pulse on a dropped parity-bad code; present only with DEC_PARITY_EN

## Operation
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Storage: DEPTH-entry FIFO of 3-bit codes, then one output register holding the 8-bit one-hot value. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Output register loads the decoded FIFO head whenever the register is empty or is being consumed in the same cycle. FIFO empty and register consumed gives out_valid = 0 next cycle.
- Bypass: FIFO empty, output register empty or being consumed, and an input transfer occurring -> the code is decoded straight into the output register without being written to the FIFO.
- in_ready = !fifo_full. Full FIFO with a simultaneous output transfer still deasserts in_ready for that cycle; no push-on-pop when full.
- Simultaneous push and pop on a partially filled FIFO: both occur, FIFO occupancy unchanged.
- out_onehot = 8'h00 whenever out_valid = 0. Exactly one bit is set when out_valid = 1.
- Held output is stable: while out_valid && !out_ready, out_onehot does not change.
- flush = 1: next edge empties FIFO and output register and forces count = 0; any input offered in that cycle is discarded. flush has priority over all transfers.
- Reset, asynchronous mid-operation: all contents lost immediately. out_valid = 0, out_onehot = 8'h00, in_ready = 1, count = 0, par_err = 0, pointers = 0.

## Timing
- Latency: a code accepted at edge k into an empty block appears with out_valid = 1 after edge k (bypass), i.e. one cycle.
- Non-empty block: entry appears one cycle after the previous output transfer.
- Throughput: one transfer per cycle per side, sustained indefinitely with out_ready held at 1.
- in_ready, out_valid, out_onehot and count are registered or derived only from registers; there is no combinational path from in_valid or out_ready to any output.
- count updates on the same edge as the transfer causing it.

## Configuration
- DEC_PARITY_EN defined: in_par and par_err ports exist. A transfer is checked with ^{in_code,in_par}. When the result is 1 (bad parity), the handshake still completes (in_ready unaffected), the code is dropped without a FIFO write or bypass, and par_err pulses high for one cycle after the edge. count is unchanged.
- DEC_PARITY_EN undefined: no in_par and no par_err ports; every transfer is stored.

## Test plan
- Reset then single code: rst_n low→high, in_code = 3'd5 with one-cycle in_valid, out_ready = 1 -> out_valid high one cycle later with out_onehot = 8'h20, then 8'h00 / out_valid = 0.
- Fill under stall: out_ready = 0, push 0,1,2,3,4 (DEPTH = 4) -> in_ready drops after the 5th accept, count = 5. Release out_ready -> outputs 8'h01, 8'h02, 8'h04, 8'h08, 8'h10 in order on consecutive cycles.
- Streaming: codes 7,6,...,0 back-to-back with out_ready = 1 -> 8'h80 down to 8'h01, one per cycle, count ≤ 1, in_ready never drops.
- Wrap-around: 20 random codes with out_ready toggling every 3 cycles -> output sequence matches input sequence exactly; no loss, no duplicates.
- Flush and reset mid-stream: flush with 3 entries held -> count = 0 and out_valid = 0 next cycle. Assert rst_n low mid-transfer -> outputs return to reset values without waiting for a clock edge.
- DEC_PARITY_EN: in_code = 3'd3 with in_par = 1 -> dropped, par_err one-cycle pulse, count unchanged. With in_par = 0 -> 8'h08 delivered.

Source files
------------

// File: rtl/decoder3to8_buf.sv
// Buffered 3-to-8 one-hot decoder: DEPTH-entry code FIFO feeding a registered one-hot output stage.
// Latency: 1 cycle from input transfer to out_valid when empty (bypass); otherwise 1 cycle after the previous output transfer.
// Backpressure: in_ready = !fifo_full (registered); out_ready stalls hold the output stable. Optional parity check: DEC_PARITY_EN.
module decoder3to8_buf #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_code,
`ifdef DEC_PARITY_EN
  input  logic          in_par,
  output logic          par_err,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_onehot,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;
  logic          valid_q;
  logic [7:0]    onehot_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          par_bad;
  logic          in_xfer;
  logic          accept;
  logic          reg_free;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [2:0]    dec_src;
  logic [7:0]    dec_val;

  assign fifo_full  = (fcnt == CW'(DEPTH));
  assign fifo_empty = (fcnt == '0);

  // All outputs come from registers only; no path from in_valid/out_ready.
  assign in_ready   = !fifo_full;
  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;
  assign count      = fcnt + CW'(valid_q);

`ifdef DEC_PARITY_EN
  assign par_bad = ^{in_code, in_par};
`else
  assign par_bad = 1'b0;
`endif

  // Transfer qualification: a parity-bad code completes the handshake but is dropped.
  always_comb begin
    in_xfer  = in_valid && !fifo_full;
    accept   = in_xfer && !par_bad;
    reg_free = !valid_q || out_ready;
    pop      = !fifo_empty && reg_free;
    bypass   = accept && fifo_empty && reg_free;
    push     = accept && !bypass;
  end

  // Decode either the FIFO head or the bypassed input code.
  always_comb begin
    dec_src          = pop ? mem[rd_ptr] : in_code;
    dec_val          = 8'h00;
    dec_val[dec_src] = 1'b1;
  end

  // FIFO pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fcnt <= fcnt + CW'(1);
      else if (pop && !push) fcnt <= fcnt - CW'(1);
    end
  end

  // FIFO storage; contents become unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_code;
  end

  // Output stage: reload when empty or being consumed, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      onehot_q <= 8'h00;
    end else if (flush) begin
      valid_q  <= 1'b0;
      onehot_q <= 8'h00;
    end else if (reg_free) begin
      valid_q  <= pop || bypass;
      onehot_q <= (pop || bypass) ? dec_val : 8'h00;
    end
  end

`ifdef DEC_PARITY_EN
  // One-cycle pulse for each dropped parity-bad code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= !flush && in_xfer && par_bad;
  end
`endif

endmodule

// File: tb/tb_decoder3to8_buf.sv
// Directed self-checking bench for decoder3to8_buf (DEPTH = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Covers reset, bypass, fill/stall, streaming, wrap-around, flush, async reset, optional parity.
module tb_decoder3to8_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic [2:0] count;
`ifdef DEC_PARITY_EN
  logic       in_par;
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder3to8_buf #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
`ifdef DEC_PARITY_EN
    .in_par     (in_par),
    .par_err    (par_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .count      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          exp_q[$];
  logic [2:0]  codes[20];
  int          sent;
  int          recv;
  logic [7:0]  e;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_code = 3'd0; out_ready = 1'b0;
`ifdef DEC_PARITY_EN
    in_par = 1'b0;
`endif
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 8'h00);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();

    // Single code through bypass.
    in_code = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_onehot", out_onehot, 8'h20);
    chk("single_count", count, 1);
    tick();
    chk("single_drain_valid", out_valid, 0);
    chk("single_drain_onehot", out_onehot, 8'h00);
    chk("single_drain_count", count, 0);

    // Fill under stall.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", in_ready, 1);
      in_code = 3'(i); in_valid = 1'b1;
      tick();
      chk("fill_count", count, i + 1);
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_hold_onehot", out_onehot, 8'h01);
    in_code = 3'd7;
    tick();
    chk("full_reject_count", count, 5);
    chk("full_hold_onehot2", out_onehot, 8'h01);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_onehot1", out_onehot, 8'h02);
    chk("drain_count1", count, 4);
    chk("drain_ready1", in_ready, 1);
    tick();
    chk("drain_onehot2", out_onehot, 8'h04);
    tick();
    chk("drain_onehot3", out_onehot, 8'h08);
    tick();
    chk("drain_onehot4", out_onehot, 8'h10);
    chk("drain_count4", count, 1);
    tick();
    chk("drain_empty_valid", out_valid, 0);
    chk("drain_empty_count", count, 0);

    // Streaming 7..0 back-to-back.
    for (int c = 7; c >= 0; c--) begin
      in_code = 3'(c); in_valid = 1'b1;
      tick();
      e = 8'h01 << c;
      chk("stream_onehot", out_onehot, e);
      chk("stream_count", count, 1);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", out_valid, 0);

    // Wrap-around with out_ready toggling every 3 cycles.
    for (int i = 0; i < 20; i++) codes[i] = 3'($urandom_range(7, 0));
    sent = 0; recv = 0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
      if (cyc % 3 == 0) out_ready = !out_ready;
      if (sent < 20) begin in_valid = 1'b1; in_code = codes[sent]; end
      else in_valid = 1'b0;
      if (in_valid && in_ready) begin exp_q.push_back(int'(in_code)); sent++; end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("wrap_spurious", out_onehot, 8'h00);
        else begin
          e = 8'h01 << exp_q.pop_front();
          chk("wrap_onehot", out_onehot, e);
        end
        recv++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_recv", recv, 20);
    chk("wrap_sent", sent, 20);
    out_ready = 1'b1;
    tick();
    chk("wrap_no_dup", out_valid, 0);

    // Flush with 3 entries held; offered input is discarded.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_code = 3'(i); in_valid = 1'b1;
      tick();
    end
    chk("preflush_count", count, 3);
    flush = 1'b1; in_code = 3'd6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_onehot", out_onehot, 8'h00);
    tick();
    chk("flush_discard", out_valid, 0);
    out_ready = 1'b1; in_code = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("postflush_onehot", out_onehot, 8'h04);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0; in_code = 3'd4; in_valid = 1'b1;
    tick();
    in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("prereset_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_onehot", out_onehot, 8'h00);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    chk("postreset_valid", out_valid, 0);

`ifdef DEC_PARITY_EN
    // Parity-bad code dropped, good code delivered.
    out_ready = 1'b1; in_code = 3'd3; in_par = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("par_err_pulse", par_err, 1);
    chk("par_drop_valid", out_valid, 0);
    chk("par_drop_count", count, 0);
    tick();
    chk("par_err_clear", par_err, 0);
    in_par = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("par_good_onehot", out_onehot, 8'h08);
    chk("par_good_err", par_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
